alu_serial_seq: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (ALUbitN). Accepts a WIDTH-bit command,

---
 rtl/alu_serial_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_serial_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams a WIDTH-bit command LSB-first through one external
// 1-bit ALU slice, chaining the carry in a register and collecting result and flags.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             err_o,
    output logic             alu_a_o,
    output logic             alu_b_o,
    output logic             alu_c_o,
    output logic             alu_invert_o,
    output logic [4:0]       alu_op_o,
    output logic             alu_less_o,
    input  logic             alu_res_i,
    input  logic             alu_c_i
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'h00;
    localparam logic [4:0] OP_OR   = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_SLT  = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_SLTU = 5'h05;
    localparam logic [4:0] OP_SUB  = 5'h06;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESOLVE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic [4:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cin_msb, sum_msb;
    logic             accept, legal, last_bit, is_cmp, is_arith, has_ovf, less;
    logic [4:0]       map_op;
    logic             map_inv, map_c0;

    assign accept   = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign legal    = (op_i <= OP_SUB);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign is_cmp   = (op_q == OP_SLT) | (op_q == OP_SLTU);
    assign is_arith = (op_q == OP_ADD) | (op_q == OP_SUB) | is_cmp;
    assign has_ovf  = (op_q == OP_ADD) | (op_q == OP_SUB);
    assign res_next = {alu_res_i, res_sh[WIDTH-1:1]};
    // Signed compare folds in overflow; unsigned compare is "borrow occurred".
    assign less     = (op_q == OP_SLT) ? (sum_msb ^ cin_msb ^ carry_q) : ~carry_q;

    // Subtract-type ops reuse the adder with inverted B and carry-in of 1.
    always_comb begin
        map_op  = op_q;
        map_inv = 1'b0;
        map_c0  = 1'b0;
        case (op_q)
            OP_ADD:                  map_op = OP_ADD;
            OP_SUB, OP_SLT, OP_SLTU: begin
                map_op  = OP_ADD;
                map_inv = 1'b1;
                map_c0  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        alu_a_o      = 1'b0;
        alu_b_o      = 1'b0;
        alu_c_o      = 1'b0;
        alu_invert_o = 1'b0;
        alu_op_o     = 5'h00;
        alu_less_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (accept) state_d = legal ? S_RUN : S_DONE;
            end
            S_RUN: begin
                alu_a_o      = a_sh[0];
                alu_b_o      = b_sh[0];
                alu_c_o      = (cnt_q == '0) ? map_c0 : carry_q;
                alu_invert_o = map_inv;
                alu_op_o     = map_op;
                if (last_bit) state_d = is_cmp ? S_RESOLVE : S_DONE;
            end
            S_RESOLVE: state_d = S_DONE;
            S_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
                state_d = accept ? (legal ? S_RUN : S_DONE) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cin_msb    <= 1'b0;
            sum_msb    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            err_o      <= 1'b0;
        end else if (accept) begin
            a_sh  <= a_i;
            b_sh  <= b_i;
            op_q  <= op_i;
            cnt_q <= '0;
            if (!legal) begin
                result_o   <= '0;
                zero_o     <= 1'b1;
                carry_o    <= 1'b0;
                overflow_o <= 1'b0;
                err_o      <= 1'b1;
            end
        end else if (state_q == S_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= alu_c_i;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                cin_msb <= alu_c_o;
                sum_msb <= alu_res_i;
                if (!is_cmp) begin
                    result_o   <= res_next;
                    zero_o     <= (res_next == '0);
                    carry_o    <= is_arith & alu_c_i;
                    overflow_o <= has_ovf & (alu_c_o ^ alu_c_i);
                    err_o      <= 1'b0;
                end
            end
        end else if (state_q == S_RESOLVE) begin
            result_o   <= {{(WIDTH-1){1'b0}}, less};
            zero_o     <= ~less;
            carry_o    <= carry_q;
            overflow_o <= 1'b0;
            err_o      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit slice attached.
module tb_alu_serial_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         ready, done, zero, carry, ovf, err;
    logic [W-1:0] result;
    logic         s_a, s_b, s_c, s_inv, s_less, s_res, s_cout, s_bb;
    logic [4:0]   s_op;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .ready_o(ready), .done_o(done), .result_o(result), .zero_o(zero),
        .carry_o(carry), .overflow_o(ovf), .err_o(err),
        .alu_a_o(s_a), .alu_b_o(s_b), .alu_c_o(s_c), .alu_invert_o(s_inv),
        .alu_op_o(s_op), .alu_less_o(s_less), .alu_res_i(s_res), .alu_c_i(s_cout)
    );

    // External 1-bit slice: AND/OR/ADD/XOR with optional B inversion.
    always_comb begin
        s_bb   = s_b ^ s_inv;
        s_res  = 1'b0;
        s_cout = 1'b0;
        case (s_op)
            5'h00: s_res = s_a & s_bb;
            5'h01: s_res = s_a | s_bb;
            5'h02: begin
                s_res  = s_a ^ s_bb ^ s_c;
                s_cout = (s_a & s_bb) | (s_a & s_c) | (s_bb & s_c);
            end
            5'h04: s_res = s_a ^ s_bb;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b, res;
        logic         c, o, z, e;
        int           lat;
    } vec_t;

    vec_t vt[15];

    task automatic launch(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
    endtask

    // Counts negedges after the accept edge until done_o; mode 1 keeps
    // pulsing start with different operands while the command is running.
    task automatic wait_done(input int mode, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            start = (mode == 1) && (n < W);
            if (start) begin op = 5'h02; a = 32'd100; b = 32'd200; end
            if (done || n >= 100) break;
        end
        if (!done) chk("done timeout", 0, 1);
    endtask

    initial begin
        int n;
        vt[0]  = '{5'h02, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0, 1'b0, 1'b0, W+1};
        vt[1]  = '{5'h06, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, W+1};
        vt[2]  = '{5'h02, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, W+1};
        vt[3]  = '{5'h06, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0, W+1};
        vt[4]  = '{5'h03, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0, 1'b0, 1'b0, W+2};
        vt[5]  = '{5'h05, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0, W+2};
        vt[6]  = '{5'h03, 32'h80000000, 32'd1,        32'd1,        1'b1, 1'b0, 1'b0, 1'b0, W+2};
        vt[7]  = '{5'h02, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0, W+1};
        vt[8]  = '{5'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, W+1};
        vt[9]  = '{5'h01, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b0, W+1};
        vt[10] = '{5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0, W+1};
        vt[11] = '{5'h07, 32'd9,        32'd9,        32'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[12] = '{5'h1F, 32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[13] = '{5'h05, 32'd1,        32'd2,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0, W+2};
        vt[14] = '{5'h06, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, W+1};

        #12;
        chk("rst ready", ready, 1);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst zero", zero, 0);
        chk("rst alu", {s_a, s_b, s_c, s_inv, s_op, s_less}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            launch(vt[i].op, vt[i].a, vt[i].b);
            wait_done(0, n);
            chk($sformatf("v%0d latency", i), n, vt[i].lat);
            chk($sformatf("v%0d result", i), result, vt[i].res);
            chk($sformatf("v%0d carry", i), carry, vt[i].c);
            chk($sformatf("v%0d ovf", i), ovf, vt[i].o);
            chk($sformatf("v%0d zero", i), zero, vt[i].z);
            chk($sformatf("v%0d err", i), err, vt[i].e);
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), done, 0);
            chk($sformatf("v%0d result held", i), result, vt[i].res);
            chk($sformatf("v%0d ready", i), ready, 1);
        end

        // Starts while busy are ignored.
        launch(5'h02, 32'd5, 32'd3);
        wait_done(1, n);
        chk("busy latency", n, W+1);
        chk("busy result", result, 32'd8);

        // Back-to-back: accept SUB in the DONE cycle.
        start = 1'b1; op = 5'h06; a = 32'd3; b = 32'd5;
        @(posedge clk);
        wait_done(0, n);
        chk("b2b latency", n, W+1);
        chk("b2b result", result, 32'hFFFFFFFE);
        @(negedge clk);

        // Async reset at bit 10 of an ADD aborts the command.
        launch(5'h02, 32'd5, 32'd3);
        repeat (10) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort ready", ready, 1);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort alu", {s_a, s_b, s_c, s_inv, s_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort no done", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
